// File: rtl/resp_tx_sequencer.sv
// Byte sequencer between the sensor scheduler and the UART transmitter.
// Optional RESP_ADDR_ECHO_EN prepends the sensor address to each reply frame.
module resp_tx_sequencer #(
  parameter int GAP_CYCLES = 2,
  parameter int TX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] response_i,
  input  logic [7:0] data_i,
  input  logic [7:0] address_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_done_i,
  output logic       done_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef RESP_ADDR_ECHO_EN
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] IDX_LAST = 2'd2;
`else
  localparam int IDX_W = 1;
  localparam logic [IDX_W-1:0] IDX_LAST = 1'b1;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_resp;
  logic [7:0]       r_data;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic [7:0]       w_first;

`ifdef RESP_ADDR_ECHO_EN
  logic [7:0] r_addr;

  function automatic logic [7:0] sel_byte(input logic [IDX_W-1:0] idx,
                                          input logic [7:0] a, r, d);
    case (idx)
      2'd0:    sel_byte = a;
      2'd1:    sel_byte = r;
      default: sel_byte = d;
    endcase
  endfunction

  assign w_first = address_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_addr <= '0;
    else if (r_state == S_IDLE && en_i)
      r_addr <= address_i;
  end
`else
  logic [7:0] r_addr;
  logic       w_unused_addr;

  function automatic logic [7:0] sel_byte(input logic [IDX_W-1:0] idx,
                                          input logic [7:0] a, r, d);
    sel_byte = idx[0] ? d : r;
    if (a == 8'h00 && 1'b0) sel_byte = a;
  endfunction

  // Two-byte frame: the address has no destination, so it is only folded away.
  assign r_addr        = '0;
  assign w_first       = response_i;
  assign w_unused_addr = ^address_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_to_cnt   <= '0;
      r_gap_cnt  <= '0;
      r_resp     <= '0;
      r_data     <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en_i) begin
            r_resp     <= response_i;
            r_data     <= data_i;
            r_idx      <= '0;
            r_to_cnt   <= '0;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_first;
            r_busy     <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle still counts as success.
          if (tx_done_i) begin
            if (r_idx == IDX_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (GAP_CYCLES == 0) begin
              r_idx      <= r_idx + 1'b1;
              r_to_cnt   <= '0;
              r_tx_start <= 1'b1;
              r_tx_data  <= sel_byte(r_idx + 1'b1, r_addr, r_resp, r_data);
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_to_cnt   <= '0;
            r_tx_start <= 1'b1;
            r_tx_data  <= sel_byte(r_idx, r_addr, r_resp, r_data);
            r_state    <= S_WAIT;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_start_o = r_tx_start;
  assign tx_data_o  = r_tx_data;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign busy_o     = r_busy;

endmodule
